demux1x2_stream: RTL

DEMUX1X2_STREAM -- requirements
Module: demux1x2_stream

---
 rtl/demux_pkg.sv | 7 +
 rtl/fifo2.sv | 52 +++++
 rtl/demux1x2_stream.sv | 71 +++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared constants for the 1:2 stream demux and its per-port FIFO.
package demux_pkg;
  localparam int DEMUX_DEPTH = 2;
  localparam int CNT_W       = 16;

  typedef logic [1:0] occ_t;
endpackage

// File: rtl/fifo2.sv
// Two-entry valid/ready FIFO; head word and valid come straight from registers.
module fifo2
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_p0 [DEMUX_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  occ_t             occ;
  logic             push;
  logic             pop;

  // Readiness looks only at registered occupancy, so a pop never frees a slot in the same cycle.
  assign wr_ready = (occ != occ_t'(DEMUX_DEPTH));
  assign rd_valid = (occ != '0);
  assign rd_data  = mem_p0[rd_ptr];
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem_p0[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/demux1x2_stream.sv
// 1:2 valid/ready stream demux with an independent 2-entry FIFO per output.
// Optional DEMUX_COUNT_EN adds per-port delivered-word counters cnt0/cnt1.
module demux1x2_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  logic wr_valid0;
  logic wr_valid1;
  logic wr_ready0;
  logic wr_ready1;

  assign wr_valid0 = in_valid & ~in_sel;
  assign wr_valid1 = in_valid &  in_sel;
  // Only the selected port's fullness gates the input; in_valid plays no part.
  assign in_ready  = in_sel ? wr_ready1 : wr_ready0;

  fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
    .clk      (clk),
    .clrn     (clrn),
    .wr_valid (wr_valid0),
    .wr_ready (wr_ready0),
    .wr_data  (in_data),
    .rd_valid (out0_valid),
    .rd_ready (out0_ready),
    .rd_data  (out0_data)
  );

  fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
    .clk      (clk),
    .clrn     (clrn),
    .wr_valid (wr_valid1),
    .wr_ready (wr_ready1),
    .wr_data  (in_data),
    .rd_valid (out1_valid),
    .rd_ready (out1_ready),
    .rd_data  (out1_data)
  );

`ifdef DEMUX_COUNT_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (out0_valid && out0_ready) cnt0 <= cnt0 + 1'b1;
      if (out1_valid && out1_ready) cnt1 <= cnt1 + 1'b1;
    end
  end
`endif

endmodule
